// File: rtl/mk14_serial_loader_pkg.sv
// Shared types and constants for the MK14 serial program loader.
//   loader_state_t : frame-level FSM states
//   rx_state_t     : UART receiver states
//   clks_per_bit() : rounds system clock / line rate to the nearest whole cycle
package mk14_loader_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned LEN_W  = 9;

   localparam logic [DATA_W-1:0] SYNC_BYTE = 8'h55;

   typedef enum logic [2:0] {
      S_SYNC,
      S_AHI,
      S_ALO,
      S_LEN,
      S_DATA,
      S_CSUM
   } loader_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_START,
      R_DATA,
      R_STOP
   } rx_state_t;

   // Nearest-integer clock cycles per UART bit.
   function automatic int unsigned clks_per_bit(input int unsigned freq_mhz,
                                                input int unsigned baud);
      return (freq_mhz * 32'd1_000_000 + baud / 32'd2) / baud;
   endfunction

endpackage

// File: rtl/mk14_serial_loader_if.sv
// Byte write port from the loader into the SoC memory write mux.
//   mem_we    : one-cycle write strobe
//   mem_addr  : write address (held between strobes)
//   mem_wdata : write data (held between strobes)
// master = loader side (drives), slave = memory side (observes).
interface mk14_serial_loader_if;
   import mk14_loader_pkg::*;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;

   modport master (output mem_we, output mem_addr, output mem_wdata);
   modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);

endinterface

// File: rtl/mk14_serial_loader_uart_rx.sv
// 8N1 UART receiver with a 2-FF input synchroniser.
//   clk, rst_n : system clock, async active-low reset
//   rx         : asynchronous serial input, idle high
//   data       : last received byte (valid with byte_valid)
//   byte_valid : one-cycle pulse at stop-bit centre, stop bit high
//   frame_err  : one-cycle pulse at stop-bit centre, stop bit low
module uart_rx
   import mk14_loader_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 234
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx,
   output logic [DATA_W-1:0] data,
   output logic              byte_valid,
   output logic              frame_err
);

   localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT + 1);
   localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;

   logic              rx_meta;
   logic              rx_sync;
   logic              rx_prev;
   rx_state_t         state;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        bit_idx;
   logic [DATA_W-1:0] shreg;

   // Synchroniser plus one delay stage for falling-edge detection; idle high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // Bit-timing FSM: confirm start at half bit, then sample every full bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= R_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         data       <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            R_IDLE: begin
               cnt     <= '0;
               bit_idx <= '0;
               if (rx_prev && !rx_sync) begin
                  state <= R_START;
               end
            end
            R_START: begin
               if (cnt == CNT_W'(HALF_BIT - 1)) begin
                  cnt <= '0;
                  // Line back high at mid start bit: treat as a glitch.
                  state <= rx_sync ? R_IDLE : R_DATA;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            R_DATA: begin
               if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                  cnt     <= '0;
                  shreg   <= {rx_sync, shreg[DATA_W-1:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state <= R_STOP;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            R_STOP: begin
               if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                  cnt   <= '0;
                  state <= R_IDLE;
                  if (rx_sync) begin
                     data       <= shreg;
                     byte_valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/mk14_serial_loader.sv
// Serial program loader: receives 0x55|AHI|ALO|LEN|data*LEN|CSUM frames over
// UART and writes the data bytes into memory.
//   clk, rst_n : system clock, async active-low reset
//   rx         : UART serial input, idle high
//   rx_wait    : holds the CPU off while a frame is in flight
//   mem        : byte write port (mem_we / mem_addr / mem_wdata)
//   load_done  : one-cycle pulse, frame ended with a good checksum
//   load_err   : one-cycle pulse, frame aborted (checksum, framing, timeout)
module mk14_serial_loader
   import mk14_loader_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ_MHZ = 27,
   parameter int unsigned BAUD           = 115200,
   parameter int unsigned TIMEOUT_BITS   = 40
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        rx,
   output logic                        rx_wait,
   mk14_serial_loader_if.master        mem,
   output logic                        load_done,
   output logic                        load_err
);

   localparam int unsigned CLKS_PER_BIT   = clks_per_bit(CLOCK_FREQ_MHZ, BAUD);
   localparam int unsigned TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int unsigned GAP_W          = $clog2(TIMEOUT_CYCLES + 1);

   logic [DATA_W-1:0] rx_data;
   logic              byte_valid;
   logic              frame_err;

   loader_state_t     state;
   logic [LEN_W-1:0]  byte_cnt;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] csum;
   logic [GAP_W-1:0]  gap_cnt;

   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;

   logic              timeout_c;
   logic [DATA_W-1:0] csum_next_c;

   uart_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart_rx (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .data       (rx_data),
      .byte_valid (byte_valid),
      .frame_err  (frame_err)
   );

   assign timeout_c   = (state != S_SYNC) && (gap_cnt == GAP_W'(TIMEOUT_CYCLES));
   assign csum_next_c = csum + rx_data;

   // Idle-gap counter: restarts on each received byte, parked while hunting for sync.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_cnt <= '0;
      end else if (byte_valid || state == S_SYNC) begin
         gap_cnt <= '0;
      end else if (!timeout_c) begin
         gap_cnt <= gap_cnt + GAP_W'(1);
      end
   end

   // Frame FSM with address counter, length counter and running checksum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_SYNC;
         byte_cnt    <= '0;
         addr        <= '0;
         csum        <= '0;
         rx_wait     <= 1'b0;
         load_done   <= 1'b0;
         load_err    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         mem_we_q  <= 1'b0;
         load_done <= 1'b0;
         load_err  <= 1'b0;
         if (frame_err && state != S_SYNC) begin
            // A broken byte inside a frame aborts it; in S_SYNC it is simply dropped.
            state    <= S_SYNC;
            rx_wait  <= 1'b0;
            load_err <= 1'b1;
         end else if (byte_valid) begin
            case (state)
               S_SYNC: begin
                  if (rx_data == SYNC_BYTE) begin
                     state   <= S_AHI;
                     rx_wait <= 1'b1;
                     csum    <= '0;
                  end
               end
               S_AHI: begin
                  addr[ADDR_W-1:8] <= rx_data;
                  csum             <= csum_next_c;
                  state            <= S_ALO;
               end
               S_ALO: begin
                  addr[7:0] <= rx_data;
                  csum      <= csum_next_c;
                  state     <= S_LEN;
               end
               S_LEN: begin
                  // LEN of zero stands for a full 256-byte block.
                  byte_cnt <= (rx_data == '0) ? LEN_W'(256) : LEN_W'(rx_data);
                  csum     <= csum_next_c;
                  state    <= S_DATA;
               end
               S_DATA: begin
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= addr;
                  mem_wdata_q <= rx_data;
                  addr        <= addr + ADDR_W'(1);
                  csum        <= csum_next_c;
                  byte_cnt    <= byte_cnt - LEN_W'(1);
                  if (byte_cnt == LEN_W'(1)) begin
                     state <= S_CSUM;
                  end
               end
               S_CSUM: begin
                  state   <= S_SYNC;
                  rx_wait <= 1'b0;
                  if (csum_next_c == '0) begin
                     load_done <= 1'b1;
                  end else begin
                     load_err <= 1'b1;
                  end
               end
               default: begin
                  state   <= S_SYNC;
                  rx_wait <= 1'b0;
               end
            endcase
         end else if (timeout_c) begin
            state    <= S_SYNC;
            rx_wait  <= 1'b0;
            load_err <= 1'b1;
         end
      end
   end

   assign mem.mem_we    = mem_we_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mk14_serial_loader.sv
// Self-checking bench for mk14_serial_loader. Runs the line at 16 clocks per
// bit so a full 256-byte frame stays short; the timeout scales with it.
module tb_mk14_serial_loader;
   import mk14_loader_pkg::*;

   localparam int unsigned CLOCK_FREQ_MHZ = 27;
   localparam int unsigned BAUD           = 1_687_500;
   localparam int unsigned TIMEOUT_BITS   = 40;
   localparam int          CPB            = 16;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_t;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  len;
      logic [7:0]  d0;
      logic [7:0]  step;
      logic [7:0]  csum_adj;
      int          exp_done;
      int          exp_err;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic rx    = 1'b1;
   logic rx_wait;
   logic load_done;
   logic load_err;

   int checks   = 0;
   int errors   = 0;
   int wr_cnt   = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   wr_t exp_q[$];
   wr_t exp_w;
   vec_t vecs[4];
   int w0, d0, e0, k;

   mk14_serial_loader_if mem ();

   mk14_serial_loader #(
      .CLOCK_FREQ_MHZ (CLOCK_FREQ_MHZ),
      .BAUD           (BAUD),
      .TIMEOUT_BITS   (TIMEOUT_BITS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .rx_wait   (rx_wait),
      .mem       (mem),
      .load_done (load_done),
      .load_err  (load_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard side: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem.mem_we) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got addr=%h data=%h expected no write",
                        mem.mem_addr, mem.mem_wdata);
            end else begin
               exp_w = exp_q.pop_front();
               check("write_addr", 32'(mem.mem_addr), 32'(exp_w.addr));
               check("write_data", 32'(mem.mem_wdata), 32'(exp_w.data));
            end
         end
         if (load_done) done_cnt++;
         if (load_err)  err_cnt++;
         if (load_done || load_err)
            check("done_err_exclusive", 32'(load_done & load_err), 32'd0);
      end
   end

   // Drive one 8N1 character, starting and ending on a falling clock edge.
   task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_bit;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic idle_bits(input int n);
      repeat (n * CPB) @(negedge clk);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int          n, wb, db, eb;
      logic [7:0]  sum, b;
      logic [15:0] a;
      n   = (v.len == 8'd0) ? 256 : int'(v.len);
      wb  = wr_cnt;
      db  = done_cnt;
      eb  = err_cnt;
      sum = 8'(v.addr[15:8] + v.addr[7:0] + v.len);
      send_byte(SYNC_BYTE);
      check($sformatf("vec%0d_wait_after_sync", idx), 32'(rx_wait), 32'd1);
      send_byte(v.addr[15:8]);
      send_byte(v.addr[7:0]);
      send_byte(v.len);
      a = v.addr;
      b = v.d0;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back('{addr: a, data: b});
         sum = 8'(sum + b);
         send_byte(b);
         a = 16'(a + 16'd1);
         b = 8'(b + v.step);
      end
      check($sformatf("vec%0d_wait_before_csum", idx), 32'(rx_wait), 32'd1);
      send_byte(8'(8'h00 - sum + v.csum_adj));
      idle_bits(2);
      check($sformatf("vec%0d_writes", idx), 32'(wr_cnt - wb), 32'(n));
      check($sformatf("vec%0d_done", idx), 32'(done_cnt - db), 32'(v.exp_done));
      check($sformatf("vec%0d_err", idx), 32'(err_cnt - eb), 32'(v.exp_err));
      check($sformatf("vec%0d_wait_end", idx), 32'(rx_wait), 32'd0);
      check($sformatf("vec%0d_queue_empty", idx), 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1);
   end

   initial begin
      // Frame 0: sum 02+00+03+AA+BB+CC = 0x36, so CSUM=CA closes it to zero.
      // Frame 1: CSUM=C9, one short, must fail after writing all data.
      vecs[0] = '{16'h0200, 8'h03, 8'hAA, 8'h11, 8'h00, 1, 0};
      vecs[1] = '{16'h0200, 8'h03, 8'hAA, 8'h11, 8'hFF, 0, 1};
      vecs[2] = '{16'hFFFE, 8'h03, 8'h10, 8'h11, 8'h00, 1, 0};
      vecs[3] = '{16'h1234, 8'h00, 8'h00, 8'h07, 8'h00, 1, 0};

      // Reset state.
      repeat (5) @(negedge clk);
      check("rst_rx_wait",   32'(rx_wait),       32'd0);
      check("rst_mem_we",    32'(mem.mem_we),    32'd0);
      check("rst_mem_addr",  32'(mem.mem_addr),  32'd0);
      check("rst_mem_wdata", 32'(mem.mem_wdata), 32'd0);
      check("rst_load_done", 32'(load_done),     32'd0);
      check("rst_load_err",  32'(load_err),      32'd0);
      rst_n = 1'b1;
      idle_bits(2);

      for (int i = 0; i < 4; i++) begin
         run_vec(vecs[i], i);
         idle_bits(2);
      end

      // Timeout: line stops after ADDR_LO.
      e0 = err_cnt;
      send_byte(SYNC_BYTE);
      send_byte(8'h00);
      send_byte(8'h10);
      repeat (600) @(negedge clk);
      check("timeout_not_early", 32'(err_cnt - e0), 32'd0);
      check("timeout_wait_held", 32'(rx_wait), 32'd1);
      k = 0;
      while (err_cnt == e0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("timeout_err", 32'(err_cnt - e0), 32'd1);
      check("timeout_wait_low", 32'(rx_wait), 32'd0);
      idle_bits(2);
      run_vec(vecs[0], 10);
      idle_bits(2);

      // Noise before sync: short glitch, junk bytes, junk with bad stop bit.
      w0 = wr_cnt;
      d0 = done_cnt;
      e0 = err_cnt;
      rx = 1'b0;
      repeat (6) @(negedge clk);
      rx = 1'b1;
      idle_bits(3);
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h3C, 1'b0);
      idle_bits(2);
      check("noise_wait", 32'(rx_wait), 32'd0);
      check("noise_writes", 32'(wr_cnt - w0), 32'd0);
      check("noise_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);

      // Stop bit forced low mid-DATA.
      w0 = wr_cnt;
      d0 = done_cnt;
      e0 = err_cnt;
      send_byte(SYNC_BYTE);
      send_byte(8'h00);
      send_byte(8'h40);
      send_byte(8'h02);
      exp_q.push_back('{addr: 16'h0040, data: 8'h5A});
      send_byte(8'h5A);
      send_byte(8'hA5, 1'b0);
      idle_bits(2);
      check("ferr_err", 32'(err_cnt - e0), 32'd1);
      check("ferr_done", 32'(done_cnt - d0), 32'd0);
      check("ferr_wait", 32'(rx_wait), 32'd0);
      check("ferr_writes", 32'(wr_cnt - w0), 32'd1);

      // Reset mid-DATA, partway through a character.
      w0 = wr_cnt;
      d0 = done_cnt;
      e0 = err_cnt;
      send_byte(SYNC_BYTE);
      send_byte(8'h00);
      send_byte(8'h80);
      send_byte(8'h04);
      exp_q.push_back('{addr: 16'h0080, data: 8'h01});
      send_byte(8'h01);
      exp_q.push_back('{addr: 16'h0081, data: 8'h02});
      send_byte(8'h02);
      rx = 1'b0;
      repeat (3 * CPB) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_rx_wait",   32'(rx_wait),       32'd0);
      check("midrst_mem_we",    32'(mem.mem_we),    32'd0);
      check("midrst_mem_addr",  32'(mem.mem_addr),  32'd0);
      check("midrst_mem_wdata", 32'(mem.mem_wdata), 32'd0);
      rx = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      idle_bits(4);
      check("midrst_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
      check("midrst_wait_after", 32'(rx_wait), 32'd0);
      check("midrst_writes", 32'(wr_cnt - w0), 32'd2);

      // Loader recovers after reset.
      run_vec(vecs[2], 20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
